ad_frame_capture: RTL
=====================

AD_FRAME_CAPTURE -- requirements
Module: ad_frame_capture

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 1024, samples per frame (2..65535).
REQ-002 SHALL have parameter DEC_W, default 8, decimation register width.
REQ-003 SHALL have port sys_clk  in  1  ADC sample clock (65 MHz, same clock that drives ad_porta_clk).
REQ-004 SHALL have port sys_rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports ad_porta_data / ad_portb_data  in  14 each  ADC offset-binary samples.
REQ-006 SHALL have ports ad_ofa / ad_ofb  in  1 each  ADC overrange flags.
REQ-007 SHALL have ports arm  in  1  start-capture pulse, and force_trig  in  1  immediate trigger.
REQ-008 SHALL have port trig_level  in  14  signed two's-complement channel-A threshold.
REQ-009 SHALL have port decim  in  DEC_W  keep one sample in decim; 0 and 1 both mean keep every sample.
REQ-010 SHALL have ports m_tdata out 32, m_tvalid out 1, m_tready in 1, m_tlast out 1  output sample stream.
REQ-011 SHALL have status outputs busy, done (1-cycle pulse), ovr_a, ovr_b, drop_err  out  1 each.

Function
REQ-012 SHALL register both ADC buses and OF flags on every sys_clk edge (stage 1).
REQ-013 SHALL convert offset binary to two's complement by inverting bit 13, then sign-extend to 16 bits.
REQ-014 SHALL pack m_tdata = {chB[15:0], chA[15:0]}.
REQ-015 SHALL implement states IDLE, ARMED, CAPTURE, FLUSH.
REQ-016 IDLE->ARMED on arm; arm in ARMED/CAPTURE/FLUSH is ignored.
REQ-017 On the ARMED->transition, ovr_a, ovr_b, drop_err SHALL clear and the previous-A register SHALL load the current sample.
REQ-018 ARMED->CAPTURE on rising crossing (prev_A < trig_level and cur_A >= trig_level, signed) or on force_trig; simultaneous crossing and force_trig give one trigger.
REQ-019 The triggering sample SHALL be sample 0 of the frame; the decimation counter SHALL reset at trigger.
REQ-020 In CAPTURE, every max(decim,1)-th stage-1 sample SHALL be issued, starting with sample 0; decim is sampled at trigger and held for the frame.
REQ-021 An issued sample SHALL appear on m_tdata with m_tvalid=1 two sys_clk edges after it was on ad_port*_data.
REQ-022 m_tdata/m_tlast SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-023 If a sample is due while a held beat is unaccepted, the new sample SHALL be dropped, drop_err SHALL set (sticky), and the frame counter SHALL still advance.
REQ-024 m_tlast SHALL be 1 on issued sample FRAME_LEN-1; if that sample is dropped, the held beat's m_tlast SHALL be set to 1.
REQ-025 After the last sample is issued or dropped: CAPTURE->FLUSH; FLUSH->IDLE when the tlast beat is accepted, with done=1 for that one cycle.
REQ-026 ovr_a/ovr_b SHALL set (sticky) when ad_ofa/ad_ofb is high in stage 1 during CAPTURE.
REQ-027 busy SHALL be 1 in ARMED, CAPTURE, FLUSH.

Reset
REQ-028 Asserting sys_rst_n low at any time SHALL force state IDLE and clear m_tvalid, m_tlast, m_tdata, busy, done, ovr_a, ovr_b, drop_err, and all counters; any frame in progress is discarded.

Structure
REQ-029 State encoding and the offset-to-two's-complement conversion width constant SHALL live in shared package ad_pkg.
REQ-030 The output register with valid/ready hold SHALL be sub-module ad_stream_reg.

Verification
REQ-031 Ramp on A crossing trig_level=0, FRAME_LEN=8, decim=1, m_tready=1 -> 8 beats, first = crossing sample, tlast on beat 8, done once.
REQ-032 force_trig in ARMED with flat input 0x2000 -> frame of m_tdata=0x0000_0000 words, 8 beats.
REQ-033 decim=4, FRAME_LEN=8 -> beats carry samples 0,4,...,28 after trigger, m_tvalid high 1 of every 4 cycles.
REQ-034 m_tready=0 for 3 cycles mid-frame, decim=1 -> held beat stable, 3 samples dropped, drop_err=1, frame ends on time.
REQ-035 ad_ofb pulsed once in CAPTURE -> ovr_b=1 until next arm; ovr_a stays 0.
REQ-036 sys_rst_n low mid-CAPTURE -> all outputs 0 next cycle; after release, arm restarts cleanly.

Source files
------------

// File: rtl/ad_pkg.sv
// Shared definitions for the ADC frame capture block: capture state
// encoding and the offset-binary to two's-complement sample conversion.
package ad_pkg;

  localparam int ADC_W = 14;  // raw converter sample width
  localparam int SMP_W = 16;  // sign-extended sample width on the stream

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  // Offset binary maps to two's complement by flipping the MSB; the result
  // is then sign-extended to the stream sample width.
  function automatic logic signed [SMP_W-1:0] ob_to_tc(input logic [ADC_W-1:0] ob);
    logic [ADC_W-1:0] tc;
    tc = {~ob[ADC_W-1], ob[ADC_W-2:0]};
    return {{(SMP_W-ADC_W){tc[ADC_W-1]}}, tc};
  endfunction

endpackage

// File: rtl/ad_stream_reg.sv
// Single-entry output register with valid/ready hold. A load that arrives
// while an unaccepted beat is held is dropped; if that dropped load was the
// end of the frame, the held beat inherits the last marker instead.
module ad_stream_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              last,
  input  logic              ready,
  output logic [DATA_W-1:0] tdata,
  output logic              tvalid,
  output logic              tlast,
  output logic              drop
);

  assign drop = load && tvalid && !ready;

  // Hold the beat until accepted; take a new one when the slot is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (load && (!tvalid || ready)) begin
      tdata  <= data;
      tlast  <= last;
      tvalid <= 1'b1;
    end else if (tvalid && ready) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (drop && last) begin
      tlast  <= 1'b1;
    end
  end

endmodule

// File: rtl/ad_frame_capture.sv
// Dual-channel ADC frame capture: registers the converter buses, waits for
// a rising threshold crossing on channel A (or a forced trigger), then
// streams FRAME_LEN decimated sample pairs out through a valid/ready port.
module ad_frame_capture
  import ad_pkg::*;
#(
  parameter int FRAME_LEN = 1024,
  parameter int DEC_W     = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [ADC_W-1:0]        ad_porta_data,
  input  logic [ADC_W-1:0]        ad_portb_data,
  input  logic                    ad_ofa,
  input  logic                    ad_ofb,
  input  logic                    arm,
  input  logic                    force_trig,
  input  logic signed [ADC_W-1:0] trig_level,
  input  logic [DEC_W-1:0]        decim,
  output logic [31:0]             m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    busy,
  output logic                    done,
  output logic                    ovr_a,
  output logic                    ovr_b,
  output logic                    drop_err
);

  state_t                  state, state_nx;
  logic [ADC_W-1:0]        a_raw_p1, b_raw_p1;
  logic                    of_a_p1, of_b_p1;
  logic signed [SMP_W-1:0] cur_a, cur_b, prev_a, trig_ext;
  logic [15:0]             cnt;
  logic [DEC_W-1:0]        dec_cnt, keep, decim_eff;
  logic                    crossing, trig, arm_go, issue, last, drop;

  // Stage 1: converter data capture (datapath, no reset needed)
  always_ff @(posedge sys_clk) begin
    a_raw_p1 <= ad_porta_data;
    b_raw_p1 <= ad_portb_data;
  end

  // Stage 1: overrange flags, reset so the sticky flags never see junk
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      of_a_p1 <= 1'b0;
      of_b_p1 <= 1'b0;
    end else begin
      of_a_p1 <= ad_ofa;
      of_b_p1 <= ad_ofb;
    end
  end

  assign cur_a     = ob_to_tc(a_raw_p1);
  assign cur_b     = ob_to_tc(b_raw_p1);
  assign trig_ext  = SMP_W'(trig_level);
  assign crossing  = (prev_a < trig_ext) && (cur_a >= trig_ext);
  assign trig      = crossing || force_trig;
  assign decim_eff = (decim == '0) ? DEC_W'(1) : decim;
  assign busy      = (state != IDLE);

  // Previous channel-A sample for edge detection, tracked while armed
  always_ff @(posedge sys_clk) begin
    if (arm_go || state == ARMED) prev_a <= cur_a;
  end

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nx;
  end

  // Next-state logic and per-cycle issue/last/done decisions
  always_comb begin
    state_nx = state;
    arm_go   = 1'b0;
    issue    = 1'b0;
    last     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (arm) begin
          arm_go   = 1'b1;
          state_nx = ARMED;
        end
      end
      ARMED: begin
        if (trig) begin
          issue    = 1'b1;
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        if (dec_cnt == '0) begin
          issue = 1'b1;
          if (cnt == 16'(FRAME_LEN - 1)) begin
            last     = 1'b1;
            state_nx = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (m_tvalid && m_tready && m_tlast) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Frame/decimation counters and sticky status flags
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt      <= '0;
      dec_cnt  <= '0;
      keep     <= DEC_W'(1);
      ovr_a    <= 1'b0;
      ovr_b    <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      if (arm_go) begin
        ovr_a    <= 1'b0;
        ovr_b    <= 1'b0;
        drop_err <= 1'b0;
      end
      if (state == ARMED && trig) begin
        keep    <= decim_eff;
        cnt     <= 16'd1;
        dec_cnt <= (decim_eff == DEC_W'(1)) ? '0 : DEC_W'(1);
      end else if (state == CAPTURE) begin
        dec_cnt <= (dec_cnt == keep - DEC_W'(1)) ? '0 : dec_cnt + DEC_W'(1);
        if (issue) cnt <= cnt + 16'd1;
      end
      if (state == CAPTURE && of_a_p1) ovr_a <= 1'b1;
      if (state == CAPTURE && of_b_p1) ovr_b <= 1'b1;
      if (drop) drop_err <= 1'b1;
    end
  end

  ad_stream_reg #(.DATA_W(32)) u_out (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .load   (issue),
    .data   ({cur_b, cur_a}),
    .last   (last),
    .ready  (m_tready),
    .tdata  (m_tdata),
    .tvalid (m_tvalid),
    .tlast  (m_tlast),
    .drop   (drop)
  );

endmodule
